proc_hierarchy: RTL and testbench

- Top-level single-cycle 16-bit processor hierarchy: PC/fetch, decode with an 8x16 register file, ALU, data-memory access and writeback.
- Instruction and data memories are external; the block drives their address and control.
- Exposes per-cycle architectural trace signals (PC, instruction, register write, memory access, halt, cycle count) for the simulation trace and log harness.

---
 rtl/proc_pkg.sv | 68 ++++++
 rtl/proc_regfile.sv | 32 +++
 rtl/proc_hierarchy.sv | 159 +++++++++++++++
 tb/tb_proc_hierarchy.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the single-cycle 16-bit processor: opcodes, ALU
// function codes, instruction field positions and immediate helpers.
package proc_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_AW   = 3;
  localparam int NUM_REGS = 8;

  // Opcodes (inst[15:11])
  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_NOP  = 5'b00001;
  localparam logic [4:0] OP_J    = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_SUBI = 5'b01001;
  localparam logic [4:0] OP_BEQZ = 5'b01100;
  localparam logic [4:0] OP_ST   = 5'b10000;
  localparam logic [4:0] OP_LD   = 5'b10001;
  localparam logic [4:0] OP_LBI  = 5'b11000;
  localparam logic [4:0] OP_ALU  = 5'b11011;

  // ALU function codes (inst[1:0])
  localparam logic [1:0] FN_ADD  = 2'b00;
  localparam logic [1:0] FN_SUB  = 2'b01;  // Rt - Rs
  localparam logic [1:0] FN_XOR  = 2'b10;
  localparam logic [1:0] FN_ANDN = 2'b11;  // Rs & ~Rt

  // Instruction field positions
  localparam int OP_HI = 15;
  localparam int OP_LO = 11;
  localparam int RS_HI = 10;
  localparam int RS_LO = 8;
  localparam int RT_HI = 7;
  localparam int RT_LO = 5;
  localparam int RD_HI = 4;
  localparam int RD_LO = 2;

  // Run state: once HALT commits the core stays parked until reset.
  typedef enum logic {
    RUN_ACTIVE = 1'b0,
    RUN_HALTED = 1'b1
  } run_state_e;

  function automatic logic [DATA_W-1:0] sext5(input logic [4:0] v);
    return {{(DATA_W-5){v[4]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
    return {{(DATA_W-8){v[7]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] sext11(input logic [10:0] v);
    return {{(DATA_W-11){v[10]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] alu_op(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [1:0]        fn);
    logic [DATA_W-1:0] r;
    case (fn)
      FN_ADD:  r = a + b;
      FN_SUB:  r = b - a;
      FN_XOR:  r = a ^ b;
      default: r = a & ~b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/proc_regfile.sv
// 8x16 register file: two combinational read ports, one synchronous write
// port. A read of the register being written returns the old value because
// the write only lands at the clock edge.
module proc_regfile
  import proc_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [REG_AW-1:0] raddr_a_i,
  input  logic [REG_AW-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // Register storage: cleared by reset, single write per cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/proc_hierarchy.sv
// Single-cycle 16-bit processor: fetch, decode, register read, ALU, data
// memory access and writeback all resolve within one clock. Architectural
// trace signals are exported combinationally for the simulation harness.
module proc_hierarchy
  import proc_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          CYCLE_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [15:0]        imem_addr,
  input  logic [15:0]        imem_rdata,
  output logic [15:0]        dmem_addr,
  output logic [15:0]        dmem_wdata,
  output logic               dmem_en,
  output logic               dmem_wr,
  input  logic [15:0]        dmem_rdata,
  output logic [15:0]        pc,
  output logic [15:0]        inst,
  output logic               reg_write,
  output logic [2:0]         write_reg,
  output logic [15:0]        write_data,
  output logic               mem_read,
  output logic               mem_write,
  output logic [15:0]        mem_addr,
  output logic [15:0]        mem_data_in,
  output logic [15:0]        mem_data_out,
  output logic               halt,
  output logic [CYCLE_W-1:0] cycle_count
);

  logic [15:0]        pc_q, pc_d;
  run_state_e         state_q, state_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;

  logic [4:0]  op;
  logic [2:0]  rs_a, rt_a, rd_a;
  logic [1:0]  fn;
  logic [15:0] rs_val, rt_val;
  logic [15:0] pc_plus2, eff_addr;

  logic        wr_en, ld_op, st_op, halt_op, active;
  logic [2:0]  wr_reg;
  logic [15:0] wr_data, next_pc;

  assign op   = imem_rdata[OP_HI:OP_LO];
  assign rs_a = imem_rdata[RS_HI:RS_LO];
  assign rt_a = imem_rdata[RT_HI:RT_LO];
  assign rd_a = imem_rdata[RD_HI:RD_LO];
  assign fn   = imem_rdata[1:0];

  proc_regfile u_regfile (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .raddr_a_i (rs_a),
    .raddr_b_i (rt_a),
    .rdata_a_o (rs_val),
    .rdata_b_o (rt_val),
    .we_i      (reg_write),
    .waddr_i   (wr_reg),
    .wdata_i   (wr_data)
  );

  assign pc_plus2 = pc_q + 16'd2;
  assign eff_addr = rs_val + sext5(imem_rdata[4:0]);

  // Decode and execute: destination, result, memory strobes and next PC.
  always_comb begin
    wr_en   = 1'b0;
    ld_op   = 1'b0;
    st_op   = 1'b0;
    halt_op = 1'b0;
    wr_reg  = rt_a;
    wr_data = eff_addr;
    next_pc = pc_plus2;
    case (op)
      OP_HALT: begin
        halt_op = 1'b1;
        next_pc = pc_q;
      end
      OP_ADDI: begin
        wr_en   = 1'b1;
        wr_data = eff_addr;
      end
      OP_SUBI: begin
        wr_en   = 1'b1;
        wr_data = sext5(imem_rdata[4:0]) - rs_val;
      end
      OP_ST: st_op = 1'b1;
      OP_LD: begin
        ld_op   = 1'b1;
        wr_en   = 1'b1;
        wr_data = dmem_rdata;
      end
      OP_LBI: begin
        wr_en   = 1'b1;
        wr_reg  = rs_a;
        wr_data = sext8(imem_rdata[7:0]);
      end
      OP_ALU: begin
        wr_en   = 1'b1;
        wr_reg  = rd_a;
        wr_data = alu_op(rs_val, rt_val, fn);
      end
      OP_BEQZ: begin
        if (rs_val == 16'd0) next_pc = pc_plus2 + sext8(imem_rdata[7:0]);
      end
      OP_J: next_pc = pc_plus2 + sext11(imem_rdata[10:0]);
      default: ;
    endcase
  end

  // Strobes are suppressed in reset and once halted so nothing commits.
  assign active    = rst_n && (state_q == RUN_ACTIVE);
  assign reg_write = active && wr_en;
  assign mem_read  = active && ld_op;
  assign mem_write = active && st_op;
  assign dmem_en   = mem_read || mem_write;
  assign dmem_wr   = mem_write;
  assign halt      = rst_n && ((state_q == RUN_HALTED) || halt_op);

  assign dmem_addr    = eff_addr;
  assign dmem_wdata   = rt_val;
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign inst         = imem_rdata;
  assign write_reg    = wr_reg;
  assign write_data   = wr_data;
  assign mem_addr     = eff_addr;
  assign mem_data_in  = rt_val;
  assign mem_data_out = dmem_rdata;
  assign cycle_count  = cycle_q;

  // Next-state: PC freezes and run state latches HALTED once HALT executes.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (state_q == RUN_ACTIVE) begin
      pc_d = next_pc;
      if (halt_op) state_d = RUN_HALTED;
    end
    cycle_d = cycle_q + CYCLE_W'(1);
  end

  // Architectural state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= RUN_ACTIVE;
      cycle_q <= '0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      cycle_q <= cycle_d;
    end
  end

endmodule

// File: tb/tb_proc_hierarchy.sv
// Bench for proc_hierarchy: directed program table, hand-written halt /
// branch / async-reset sequences, and random programs checked against an
// instruction-level reference model.
module tb_proc_hierarchy;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_en, dmem_wr;
  logic [15:0] pc, inst, write_data, mem_addr, mem_data_in, mem_data_out;
  logic        reg_write, mem_read, mem_write, halt;
  logic [2:0]  write_reg;
  logic [31:0] cycle_count;

  logic [15:0] imem      [256];
  logic [15:0] dmem      [256];
  logic [15:0] dmem_init [256];
  logic        dmem_load = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  proc_hierarchy #(.RESET_PC(16'h0000), .CYCLE_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_en(dmem_en), .dmem_wr(dmem_wr), .dmem_rdata(dmem_rdata),
    .pc(pc), .inst(inst), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .halt(halt), .cycle_count(cycle_count)
  );

  assign imem_rdata = imem[imem_addr[8:1]];
  assign dmem_rdata = dmem[dmem_addr[7:0]];

  always @(posedge clk) begin
    if (dmem_load) begin
      for (int i = 0; i < 256; i++) dmem[i] <= dmem_init[i];
    end else if (dmem_en && dmem_wr) begin
      dmem[dmem_addr[7:0]] <= dmem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    dmem_load = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    dmem_load = 1'b0;
    #1;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0800;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [15:0] pc;
    logic [15:0] inst;
    logic        rw;
    logic [2:0]  wreg;
    logic [15:0] wdata;
    logic        mr;
    logic        mw;
    logic [15:0] maddr;
    logic [15:0] mdin;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [15:0] p, input logic [15:0] ins, input logic rw,
                     input logic [2:0] wreg, input logic [15:0] wdata,
                     input logic mr, input logic mw,
                     input logic [15:0] maddr, input logic [15:0] mdin);
    vec_t v;
    v.pc = p; v.inst = ins; v.rw = rw; v.wreg = wreg; v.wdata = wdata;
    v.mr = mr; v.mw = mw; v.maddr = maddr; v.mdin = mdin;
    tbl.push_back(v);
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_regs [8];
  logic [15:0] m_mem  [256];
  logic [15:0] m_pc;
  int          m_cyc;

  task automatic model_eval(input logic [15:0] ins,
                            output logic e_rw, output logic [2:0] e_wreg,
                            output logic [15:0] e_wdata, output logic e_mr,
                            output logic e_mw, output logic [15:0] e_maddr,
                            output logic [15:0] e_mdin, output logic [15:0] e_npc);
    int a, b, i5, i8, d11;
    a   = int'(m_regs[ins[10:8]]);
    b   = int'(m_regs[ins[7:5]]);
    i5  = $signed(ins[4:0]);
    i8  = $signed(ins[7:0]);
    d11 = $signed(ins[10:0]);
    e_rw = 1'b0; e_wreg = ins[7:5]; e_wdata = 16'h0; e_mr = 1'b0; e_mw = 1'b0;
    e_maddr = 16'(a + i5);
    e_mdin  = 16'(b);
    e_npc   = 16'(int'(m_pc) + 2);
    case (ins[15:11])
      5'b01000: begin e_rw = 1'b1; e_wdata = 16'(a + i5); end
      5'b01001: begin e_rw = 1'b1; e_wdata = 16'(i5 - a); end
      5'b10000: e_mw = 1'b1;
      5'b10001: begin e_mr = 1'b1; e_rw = 1'b1; e_wdata = m_mem[e_maddr[7:0]]; end
      5'b11000: begin e_rw = 1'b1; e_wreg = ins[10:8]; e_wdata = 16'(i8); end
      5'b11011: begin
        e_rw = 1'b1;
        e_wreg = ins[4:2];
        case (ins[1:0])
          2'd0:    e_wdata = 16'(a + b);
          2'd1:    e_wdata = 16'(b - a);
          2'd2:    e_wdata = 16'(a ^ b);
          default: e_wdata = 16'(a & ~b);
        endcase
      end
      5'b01100: if (a == 0) e_npc = 16'(int'(m_pc) + 2 + i8);
      5'b00100: e_npc = 16'(int'(m_pc) + 2 + d11);
      default: ;
    endcase
  endtask

  function automatic logic [15:0] rand_inst();
    logic [15:0] w;
    logic [7:0]  off;
    int k;
    k   = int'($urandom_range(0, 9));
    w   = 16'($urandom);
    off = 8'($urandom_range(0, 16));
    case (k)
      0: w[15:11] = 5'b01000;
      1: w[15:11] = 5'b01001;
      2: w[15:11] = 5'b10000;
      3: w[15:11] = 5'b10001;
      4, 5: w[15:11] = 5'b11000;
      6: w[15:11] = 5'b11011;
      7: begin w[15:11] = 5'b01100; w[7:0] = off; end
      8: begin w[15:11] = 5'b00100; w[10:0] = {3'b000, off}; end
      default: if (w[15:11] == 5'b00000) w[15:11] = 5'b00001;
    endcase
    return w;
  endfunction

  initial begin
    logic [15:0] v;
    logic        e_rw, e_mr, e_mw;
    logic [2:0]  e_wreg;
    logic [15:0] e_wdata, e_maddr, e_mdin, e_npc;

    for (int i = 0; i < 256; i++) dmem_init[i] = 16'h0000;

    // ---- directed program table ----
    add(16'h0000, 16'hC17F, 1, 1, 16'h007F, 0, 0, 0, 0);
    add(16'h0002, 16'hC280, 1, 2, 16'hFF80, 0, 0, 0, 0);
    add(16'h0004, 16'hC105, 1, 1, 16'h0005, 0, 0, 0, 0);
    add(16'h0006, 16'hC203, 1, 2, 16'h0003, 0, 0, 0, 0);
    add(16'h0008, 16'hD94C, 1, 3, 16'h0008, 0, 0, 0, 0);
    add(16'h000A, 16'hD951, 1, 4, 16'hFFFE, 0, 0, 0, 0);
    add(16'h000C, 16'hC2BF, 1, 2, 16'hFFBF, 0, 0, 0, 0);
    v = 16'hFFBF;
    for (int k = 0; k < 8; k++) begin
      v = {v[14:0], 1'b0};
      add(16'(16'h000E + 2 * k), 16'hDA48, 1, 2, v, 0, 0, 0, 0);
    end
    add(16'h001E, 16'hC5EF, 1, 5, 16'hFFEF, 0, 0, 0, 0);
    add(16'h0020, 16'hDAA8, 1, 2, 16'hBEEF, 0, 0, 0, 0);
    add(16'h0022, 16'hC110, 1, 1, 16'h0010, 0, 0, 0, 0);
    add(16'h0024, 16'h8142, 0, 0, 16'h0000, 0, 1, 16'h0012, 16'hBEEF);
    add(16'h0026, 16'h8962, 1, 3, 16'hBEEF, 1, 0, 16'h0012, 16'h0000);
    add(16'h0028, 16'hC100, 1, 1, 16'h0000, 0, 0, 0, 0);
    add(16'h002A, 16'h6104, 0, 0, 16'h0000, 0, 0, 0, 0);
    add(16'h0030, 16'hC101, 1, 1, 16'h0001, 0, 0, 0, 0);
    add(16'h0032, 16'h6104, 0, 0, 16'h0000, 0, 0, 0, 0);
    add(16'h0034, 16'h417F, 1, 3, 16'h0000, 0, 0, 0, 0);
    add(16'h0036, 16'h4982, 1, 4, 16'h0001, 0, 0, 0, 0);
    add(16'h0038, 16'h27FE, 0, 0, 16'h0000, 0, 0, 0, 0);
    add(16'h0038, 16'h27FE, 0, 0, 16'h0000, 0, 0, 0, 0);
    add(16'h0038, 16'h27FE, 0, 0, 16'h0000, 0, 0, 0, 0);

    fill_nop();
    foreach (tbl[i]) imem[tbl[i].pc[8:1]] = tbl[i].inst;

    // Reset state: strobes held low even though imem[0] is an LBI.
    @(negedge clk);
    rst_n = 1'b0;
    dmem_load = 1'b1;
    #1;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_reg_write", reg_write, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_dmem_en", dmem_en, 0);
    chk("rst_halt", halt, 0);
    chk("rst_cycle", cycle_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dmem_load = 1'b0;
    #1;

    foreach (tbl[i]) begin
      chk("tbl_pc", pc, tbl[i].pc);
      chk("tbl_inst", inst, tbl[i].inst);
      chk("tbl_reg_write", reg_write, tbl[i].rw);
      if (tbl[i].rw) begin
        chk("tbl_write_reg", write_reg, tbl[i].wreg);
        chk("tbl_write_data", write_data, tbl[i].wdata);
      end
      chk("tbl_mem_read", mem_read, tbl[i].mr);
      chk("tbl_mem_write", mem_write, tbl[i].mw);
      chk("tbl_dmem_en", dmem_en, tbl[i].mr | tbl[i].mw);
      if (tbl[i].mr || tbl[i].mw) chk("tbl_mem_addr", mem_addr, tbl[i].maddr);
      if (tbl[i].mw) chk("tbl_mem_data_in", mem_data_in, tbl[i].mdin);
      chk("tbl_halt", halt, 0);
      chk("tbl_cycle", cycle_count, i);
      step();
    end

    // ---- branch at 0x0010 taken, then J -2 at 0x0020 ----
    fill_nop();
    imem[7]  = 16'hC100;   // 0x0E: LBI R1,0
    imem[8]  = 16'h6104;   // 0x10: BEQZ R1,+4
    imem[16] = 16'h27FE;   // 0x20: J -2
    do_reset();
    repeat (8) step();
    chk("beqz_at", pc, 16'h0010);
    step();
    chk("beqz_taken", pc, 16'h0016);
    repeat (5) step();
    chk("j_at", pc, 16'h0020);
    step();
    chk("j_self1", pc, 16'h0020);
    step();
    chk("j_self2", pc, 16'h0020);

    // ---- branch at 0x0010 not taken ----
    imem[7] = 16'hC101;    // LBI R1,1
    do_reset();
    repeat (8) step();
    chk("beqz_nt_at", pc, 16'h0010);
    step();
    chk("beqz_not_taken", pc, 16'h0012);

    // ---- HALT at 0x0008 ----
    fill_nop();
    imem[4] = 16'h0000;
    do_reset();
    repeat (4) step();
    chk("halt_pc", pc, 16'h0008);
    chk("halt_now", halt, 1);
    step();
    chk("halted_pc", pc, 16'h0008);
    chk("halted_halt", halt, 1);
    chk("halted_cycle", cycle_count, 5);
    imem[4] = 16'h8142;    // a store appearing under the frozen PC
    #1;
    chk("halted_no_store", mem_write, 0);
    chk("halted_no_dmem_en", dmem_en, 0);
    chk("halted_halt_st", halt, 1);
    imem[4] = 16'hC17F;    // an LBI appearing under the frozen PC
    #1;
    chk("halted_no_regwrite", reg_write, 0);
    step();
    chk("halted_pc2", pc, 16'h0008);
    do_reset();
    chk("unhalt_pc", pc, 16'h0000);
    chk("unhalt_halt", halt, 0);
    chk("unhalt_cycle", cycle_count, 0);

    // ---- async reset in the middle of an ADDI ----
    fill_nop();
    imem[0] = 16'hC105;    // LBI R1,5
    imem[1] = 16'h4121;    // ADDI R1 = R1+1
    do_reset();
    chk("ar_lbi_data", write_data, 16'h0005);
    step();
    chk("ar_addi_rw", reg_write, 1);
    chk("ar_addi_data", write_data, 16'h0006);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_rw_clear", reg_write, 0);
    chk("ar_pc_clear", pc, 16'h0000);
    chk("ar_cycle_clear", cycle_count, 0);
    chk("ar_halt_clear", halt, 0);
    @(negedge clk);
    imem[0] = 16'h4140;    // ADDI R2 = R1+0 exposes R1
    rst_n = 1'b1;
    #1;
    chk("ar_after_rw", reg_write, 1);
    chk("ar_after_wreg", write_reg, 2);
    chk("ar_after_r1", write_data, 16'h0000);

    // ---- random programs vs reference model ----
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 256; i++) begin
        imem[i]      = rand_inst();
        dmem_init[i] = 16'($urandom);
        m_mem[i]     = dmem_init[i];
      end
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
      m_pc  = 16'h0000;
      m_cyc = 0;
      do_reset();
      for (int c = 0; c < 150; c++) begin
        v = imem[m_pc[8:1]];
        model_eval(v, e_rw, e_wreg, e_wdata, e_mr, e_mw, e_maddr, e_mdin, e_npc);
        chk("rnd_pc", pc, m_pc);
        chk("rnd_inst", inst, v);
        chk("rnd_reg_write", reg_write, e_rw);
        if (e_rw) begin
          chk("rnd_write_reg", write_reg, e_wreg);
          chk("rnd_write_data", write_data, e_wdata);
        end
        chk("rnd_mem_read", mem_read, e_mr);
        chk("rnd_mem_write", mem_write, e_mw);
        if (e_mr || e_mw) chk("rnd_mem_addr", mem_addr, e_maddr);
        if (e_mw) chk("rnd_mem_data_in", mem_data_in, e_mdin);
        if (e_mr) chk("rnd_mem_data_out", mem_data_out, m_mem[e_maddr[7:0]]);
        chk("rnd_halt", halt, 0);
        chk("rnd_cycle", cycle_count, m_cyc);
        step();
        if (e_rw) m_regs[e_wreg] = e_wdata;
        if (e_mw) m_mem[e_maddr[7:0]] = e_mdin;
        m_pc = e_npc;
        m_cyc++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
